// File: rtl/mmio_pkg.sv
// ============================================================================
// Module  : mmio_pkg
// Brief   : Shared MMIO button constants, event record and event word builder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

  localparam logic [11:0] ADDR_BTN_DATA   = 12'd7;
  localparam logic [11:0] ADDR_BTN_STATUS = 12'd11;

  localparam int EVT_VALID_BIT   = 31;
  localparam int EVT_RELEASE_BIT = 8;
  localparam int EVT_INDEX_W     = 8;

  localparam int STAT_COUNT_W   = 8;
  localparam int STAT_FULL_BIT  = 8;
  localparam int STAT_OVF_BIT   = 9;

  typedef struct packed {
    logic                   rel;
    logic [EVT_INDEX_W-1:0] index;
  } btn_event_t;

  function automatic logic [31:0] event_word(input btn_event_t e);
    logic [31:0] w;
    w                   = '0;
    w[EVT_VALID_BIT]    = 1'b1;
    w[EVT_RELEASE_BIT]  = e.rel;
    w[EVT_INDEX_W-1:0]  = e.index;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module  : button_debounce
// Brief   : 2-FF synchroniser plus stability counter; pulses change for one
//           cycle right before the accepted level flips.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic change
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_update;

  assign w_update = (r_sync2 != r_stable) && (r_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if ((r_sync2 == r_stable) || w_update)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (w_update)
        r_stable <= r_sync2;
    end
  end

  // stable still holds the old level while change is high
  assign stable = r_stable;
  assign change = w_update;

endmodule

`default_nettype wire

// File: rtl/mmio_button_fifo.sv
// ============================================================================
// Module  : mmio_button_fifo
// Brief   : Debounced button channels queue press events into a FIFO that the
//           CPU pops via lw; status/flush register. Optional RELEASE_EVENTS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mmio_button_fifo
  import mmio_pkg::*;
#(
  parameter int          NUM_BUTTONS     = 4,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [11:0] ADDR_DATA       = ADDR_BTN_DATA,
  parameter logic [11:0] ADDR_STATUS     = ADDR_BTN_STATUS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic [11:0]            mem_addr,
  input  logic                   mem_wren,
  input  logic [31:0]            mem_data_in,
  output logic                   mem_sel,
  output logic [31:0]            mem_data_out,
  output logic                   irq_pending
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [NUM_BUTTONS-1:0] w_stable, w_change, w_press;
  logic [NUM_BUTTONS-1:0] r_pend_press, w_clr_press;
  logic [NUM_BUTTONS-1:0] r_pend_rel, w_clr_rel, w_release;

  generate
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .raw    (buttons[i]),
        .stable (w_stable[i]),
        .change (w_change[i])
      );
    end
  endgenerate

  assign w_press = w_change & ~w_stable;
`ifdef RELEASE_EVENTS_EN
  assign w_release = w_change & w_stable;
`else
  assign w_release = '0;
`endif

  logic             w_sel_valid;
  btn_event_t       w_sel;

  // Scan high to low so the lowest index wins; press overrides release.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = '0;
    w_clr_press = '0;
    w_clr_rel   = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (r_pend_rel[i]) begin
        w_sel_valid  = 1'b1;
        w_sel.rel    = 1'b1;
        w_sel.index  = EVT_INDEX_W'(i);
        w_clr_press  = '0;
        w_clr_rel    = '0;
        w_clr_rel[i] = 1'b1;
      end
      if (r_pend_press[i]) begin
        w_sel_valid    = 1'b1;
        w_sel.rel      = 1'b0;
        w_sel.index    = EVT_INDEX_W'(i);
        w_clr_press    = '0;
        w_clr_rel      = '0;
        w_clr_press[i] = 1'b1;
      end
    end
  end

  btn_event_t       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow, r_prev_rd;
  logic [31:0]      r_rd_latch;

  logic w_full, w_empty, w_data_hit, w_stat_hit, w_data_rd, w_first_rd;
  logic w_pop, w_push, w_flush;
  logic [31:0] w_head, w_status;
  logic        w_unused;

  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == '0);
  assign w_data_hit = (mem_addr == ADDR_DATA);
  assign w_stat_hit = (mem_addr == ADDR_STATUS);
  assign w_data_rd  = w_data_hit && !mem_wren;
  assign w_first_rd = w_data_rd && !r_prev_rd;
  assign w_pop      = w_first_rd && !w_empty;
  assign w_push     = w_sel_valid && (!w_full || w_pop);
  assign w_flush    = w_stat_hit && mem_wren && mem_data_in[0];
  assign w_head     = event_word(r_mem[r_rd_ptr]);
  assign w_unused   = ^mem_data_in[31:1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_prev_rd    <= 1'b0;
      r_rd_latch   <= '0;
      r_pend_press <= '0;
      r_pend_rel   <= '0;
    end else begin
      r_prev_rd <= w_data_rd;
      if (w_first_rd)
        r_rd_latch <= w_empty ? 32'h0 : w_head;
      if (w_flush) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_overflow   <= 1'b0;
        r_pend_press <= '0;
        r_pend_rel   <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)
          r_count <= r_count + 1'b1;
        else if (w_pop && !w_push)
          r_count <= r_count - 1'b1;
        if (w_sel_valid && !w_push)
          r_overflow <= 1'b1;
        r_pend_press <= (r_pend_press & ~w_clr_press) | w_press;
        r_pend_rel   <= (r_pend_rel & ~w_clr_rel) | w_release;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && !w_flush)
      r_mem[r_wr_ptr] <= w_sel;
  end

  always_comb begin
    w_status                     = '0;
    w_status[STAT_COUNT_W-1:0]   = STAT_COUNT_W'(r_count);
    w_status[STAT_FULL_BIT]      = w_full;
    w_status[STAT_OVF_BIT]       = r_overflow;
  end

  // After the first cycle of a read the popped word is held from the latch.
  always_comb begin
    mem_data_out = '0;
    if (w_data_hit)
      mem_data_out = r_prev_rd ? r_rd_latch : (w_empty ? 32'h0 : w_head);
    else if (w_stat_hit)
      mem_data_out = w_status;
  end

  assign mem_sel     = w_data_hit || w_stat_hit;
  assign irq_pending = !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_mmio_button_fifo.sv
// ============================================================================
// Module  : tb_mmio_button_fifo
// Brief   : Scoreboard bench with an event-queue reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmio_button_fifo;

  localparam int NB = 4;
  localparam int DB = 4;
  localparam int FD = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] buttons = '0;
  logic [11:0]   mem_addr = '0;
  logic          mem_wren = 1'b0;
  logic [31:0]   mem_data_in = '0;
  logic          mem_sel;
  logic [31:0]   mem_data_out;
  logic          irq_pending;

  always #5 clock = ~clock;

  mmio_button_fifo #(
    .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD),
    .ADDR_DATA(12'd7), .ADDR_STATUS(12'd11)
  ) dut (
    .clock(clock), .reset(reset), .buttons(buttons), .mem_addr(mem_addr),
    .mem_wren(mem_wren), .mem_data_in(mem_data_in), .mem_sel(mem_sel),
    .mem_data_out(mem_data_out), .irq_pending(irq_pending)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] model_q[$];
  logic        model_ovf = 1'b0;
  logic [NB-1:0] held = '0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_push(input logic [31:0] w);
    if (model_q.size() == FD) model_ovf = 1'b1;
    else model_q.push_back(w);
  endfunction

  function automatic logic [31:0] model_status();
    return {22'b0, model_ovf, 1'(model_q.size() == FD), 8'(model_q.size())};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: pairs each bus read with the next queued expectation.
  logic        in_acc = 1'b0;
  logic        acc;
  logic [31:0] cur_exp = '0;
  always @(negedge clock) begin
    check("mem_sel", {31'b0, mem_sel}, {31'b0, (mem_addr == 12'd7) || (mem_addr == 12'd11)});
    acc = reset && !mem_wren && ((mem_addr == 12'd7) || (mem_addr == 12'd11));
    if (acc) begin
      if (!in_acc) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got %h expected no access", mem_data_out);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      check("read", mem_data_out, cur_exp);
    end else if (!mem_sel) begin
      check("idle_zero", mem_data_out, 32'h0);
    end
    in_acc = acc;
  end

  task automatic read_data(input int cyc);
    logic [31:0] e;
    e = (model_q.size() != 0) ? model_q.pop_front() : 32'h0;
    exp_q.push_back(e);
    mem_addr = 12'd7;
    mem_wren = 1'b0;
    tick(cyc);
    mem_addr = 12'd0;
    tick(1);
  endtask

  task automatic read_status();
    exp_q.push_back(model_status());
    mem_addr = 12'd11;
    mem_wren = 1'b0;
    tick(1);
    mem_addr = 12'd0;
    tick(1);
  endtask

  task automatic flush();
    mem_addr    = 12'd11;
    mem_wren    = 1'b1;
    mem_data_in = 32'h1;
    tick(1);
    mem_addr    = 12'd0;
    mem_wren    = 1'b0;
    mem_data_in = 32'h0;
    model_q.delete();
    model_ovf = 1'b0;
    tick(1);
  endtask

  task automatic press(input logic [NB-1:0] mask);
    logic [NB-1:0] m;
    m = mask & ~held;
    held = held | m;
    buttons = held;
    for (int i = 0; i < NB; i++)
      if (m[i]) model_push(32'h8000_0000 | 32'(i));
    tick(16);
    check("irq", {31'b0, irq_pending}, {31'b0, 1'(model_q.size() != 0)});
  endtask

  task automatic release_btn(input logic [NB-1:0] mask);
    logic [NB-1:0] m;
    m = mask & held;
    held = held & ~m;
    buttons = held;
`ifdef RELEASE_EVENTS_EN
    for (int i = 0; i < NB; i++)
      if (m[i]) model_push(32'h8000_0100 | 32'(i));
`endif
    tick(16);
  endtask

  task automatic glitch(input int idx, input int len);
    if (!held[idx]) begin
      buttons[idx] = 1'b1;
      tick(len);
      buttons = held;
      tick(12);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    tick(2);
    check("rst_irq", {31'b0, irq_pending}, 32'h0);
    check("rst_out", mem_data_out, 32'h0);
    reset = 1'b1;
    tick(2);
    read_status();

    // single press
    press(4'b0100);
    check("t1_irq", {31'b0, irq_pending}, 32'h1);
    read_data(1);
    read_data(1);
    check("t1_irq_clr", {31'b0, irq_pending}, 32'h0);
    release_btn(4'b0100);
    while (model_q.size() != 0) read_data(1);

    // glitch is filtered
    glitch(1, 2);
    read_status();

    // simultaneous rises
    press(4'b1001);
    read_data(1);
    read_data(1);
    release_btn(4'b1001);
    while (model_q.size() != 0) read_data(1);

    // overflow
    foreach (model_q[k]) model_q[k] = model_q[k];
    for (int k = 0; k < 6; k++) begin
      press(4'(1 << (k % NB)));
      release_btn(4'(1 << (k % NB)));
    end
    read_status();
    read_data(1);
    read_data(1);
    flush();
    read_status();

    // long read pops once
    press(4'b0011);
    release_btn(4'b0011);
    read_data(3);
    read_status();
    flush();

    // async reset with entries queued, button 2 held through it
    press(4'b1110);
    @(posedge clock);
    #3;
    reset = 1'b0;
    mem_addr = 12'd11;
    #1;
    check("t6_irq", {31'b0, irq_pending}, 32'h0);
    check("t6_status", mem_data_out, 32'h0);
    mem_addr = 12'd0;
    model_q.delete();
    model_ovf = 1'b0;
    tick(3);
    held = 4'b0100;
    buttons = held;
    tick(1);
    reset = 1'b1;
    model_push(32'h8000_0002);
    tick(16);
    check("t6_irq_after", {31'b0, irq_pending}, 32'h1);
    read_data(1);
    release_btn(4'b0100);
    while (model_q.size() != 0) read_data(1);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 6))
        0, 1: press(4'($urandom_range(1, 15)));
        2:    release_btn(4'($urandom_range(1, 15)));
        3:    read_data($urandom_range(1, 3));
        4:    read_status();
        5:    glitch($urandom_range(0, NB - 1), $urandom_range(1, 2));
        default: if ($urandom_range(0, 3) == 0) flush(); else read_data(1);
      endcase
    end
    release_btn(held);
    read_status();
    while (model_q.size() != 0) read_data(1);
    read_status();

    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
